tank_register_writer: RTL and testbench
=======================================

Name: tank_register_writer

Overview:
Bus-master block that owns the authoritative position and heading of every tank. Once per frame it drives the tank controllers' write port (MW/address/data), applying queued movement commands. It sits between the input/command logic and the bank of tank controllers, which sample writes on the same clk. It also clamps positions to the visible area so sprites never wrap.

Parameters:
NUM_TANKS, 2, number of tank controllers served; tank n uses tank_sel_o = n
HALF_SIZE, 16, sprite half-width in pixels; clamp margin
STEP, 4, pixels moved per frame per move command
H_RES, 640, horizontal visible width in pixels
V_RES, 480, vertical visible height in pixels

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
frame_tick_i  in  1  one-cycle pulse at start of vertical blank
cmd_valid_i  in  1  command strobe, sampled every cycle
cmd_tank_i  in  $clog2(NUM_TANKS)  target tank of command
cmd_dir_i  in  2  heading: 0 up, 1 right, 2 down, 3 left
cmd_move_i  in  1  1 = turn and step, 0 = turn only
MW_o  out  1  write enable to tank controllers
address_o  out  2  register select: 00 x, 01 y, 10 direction
data_o  out  32  write data
tank_sel_o  out  $clog2(NUM_TANKS)  tank being written; qualifies MW_o
busy_o  out  1  frame update sequence in progress
overrun_o  out  1  one-cycle pulse: frame_tick_i arrived while busy

Behaviour:
- Reset (async, immediate): MW_o=0, address_o=0, data_o=0, tank_sel_o=0, busy_o=0, overrun_o=0. Tank n: x=60+30n, y=40+30n, dir=0. All pending commands cleared. FSM to IDLE.
- Per-tank state: x, y (32-bit unsigned), dir (2-bit), pend_valid, pend_dir, pend_move.
- Command capture: cmd_valid_i=1 writes pend_* of cmd_tank_i and sets pend_valid. Last command before processing wins. Accepted in any state. cmd_tank_i >= NUM_TANKS is ignored.
- FSM: IDLE -> UPDATE -> WR_X -> WR_Y -> WR_DIR.
  - From WR_DIR: next tank goes to UPDATE; after the last tank, go to IDLE.
  - IDLE: frame_tick_i=1 sets idx=0 and moves to UPDATE.
  - UPDATE: if pend_valid, dir<=pend_dir. If pend_move is also set, step x/y along pend_dir by STEP and clamp. Clear pend_valid.
  - WR_X, WR_Y, WR_DIR: MW_o=1, tank_sel_o=idx, address_o=00/01/10, data_o=x / y / zero-extended dir.
- MW_o is registered and high only in WR_* states. busy_o=1 in every state except IDLE.
- Latency: tick sampled at cycle T, UPDATE at T+1, tank 0 writes at T+2..T+4, tank 1 UPDATE at T+5. A full sequence takes 4*NUM_TANKS cycles. Every tank is written every frame, moved or not.
- Clamp: x in [HALF_SIZE, H_RES-HALF_SIZE], y in [HALF_SIZE, V_RES-HALF_SIZE].
  - Decrement: if pos < HALF_SIZE+STEP, result = HALF_SIZE. This check prevents unsigned underflow.
  - Increment: if pos+STEP > max, result = max.
- Simultaneous cmd_valid_i and UPDATE clear on the same tank: the set wins. The new command stays pending for the next frame; the current UPDATE uses the old pending values.
- frame_tick_i while busy_o=1: ignored, overrun_o pulses for 1 cycle, no restart.
- Reset mid-sequence: MW_o drops the same instant. A partial frame is not resumed.

Decomposition:
- Package tank_pkg: dir_t enum (UP, RIGHT, DOWN, LEFT); address constants ADDR_X=2'b00, ADDR_Y=2'b01, ADDR_DIR=2'b10; FSM state enum; initial-position constants (X0=60, Y0=40, SPACING=30).
- Sub-module tank_pos_step_clamp: combinational. Inputs x, y, dir, move. Outputs next x, y. Holds all clamp arithmetic.

Test Plan:
1. Release reset, then pulse frame_tick_i -> writes (tank0: x=60, y=40, dir=0), then (tank1: x=90, y=70, dir=0) at cycles T+2..T+4 and T+6..T+8; busy_o low at T+9.
2. cmd tank0 dir=1 move=1, then tick -> tank0 writes x=64, y=40, dir=1; tank1 unchanged.
3. cmd tank0 dir=3 move=1 before each of 12 ticks -> x falls 56, 52 ... 16, stays 16 at tick 12, never wraps.
4. cmd tank1 dir=2 move=0, then tick -> tank1 writes y=70, dir=2 (turn only, no step).
5. Second tick at T+3 -> overrun_o=1 for one cycle; sequence completes unchanged and does not restart.
6. Assert rst during tank0 WR_Y -> MW_o=0 immediately; after release, the next tick writes the initial positions again.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank register writer.
package tank_pkg;

    // Tank heading as written to the controller direction register.
    typedef enum logic [1:0] {
        Up    = 2'd0,
        Right = 2'd1,
        Down  = 2'd2,
        Left  = 2'd3
    } dir_t;

    // Register select values on address_o.
    localparam logic [1:0] ADDR_X   = 2'b00;
    localparam logic [1:0] ADDR_Y   = 2'b01;
    localparam logic [1:0] ADDR_DIR = 2'b10;

    // Frame update sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StUpdate,
        StWrX,
        StWrY,
        StWrDir
    } state_t;

    // Power-on placement: tank n starts at (X0 + SPACING*n, Y0 + SPACING*n).
    localparam int unsigned X0      = 60;
    localparam int unsigned Y0      = 40;
    localparam int unsigned SPACING = 30;

    function automatic logic [31:0] init_x(input int unsigned n);
        return 32'(X0 + SPACING * n);
    endfunction

    function automatic logic [31:0] init_y(input int unsigned n);
        return 32'(Y0 + SPACING * n);
    endfunction

endpackage

// File: rtl/tank_pos_step_clamp.sv
// Combinational one-step move of a tank position along a heading, clamped so the
// sprite stays entirely inside the visible area.
module tank_pos_step_clamp
    import tank_pkg::*;
#(
    parameter int unsigned HALF_SIZE = 16,
    parameter int unsigned STEP      = 4,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480
) (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  dir_t        i_dir,
    input  logic        i_move,
    output logic [31:0] o_x,
    output logic [31:0] o_y
);

    localparam logic [31:0] PosMin   = 32'(HALF_SIZE);
    localparam logic [31:0] XMax     = 32'(H_RES - HALF_SIZE);
    localparam logic [31:0] YMax     = 32'(V_RES - HALF_SIZE);
    localparam logic [31:0] DecFloor = 32'(HALF_SIZE + STEP);
    localparam logic [31:0] Step32   = 32'(STEP);

    // Compare before subtracting so an unsigned position can never wrap below zero.
    function automatic logic [31:0] pos_dec(input logic [31:0] pos);
        return (pos < DecFloor) ? PosMin : pos - Step32;
    endfunction

    // Sum carried in 33 bits so the compare against the limit is exact.
    function automatic logic [31:0] pos_inc(input logic [31:0] pos, input logic [31:0] max);
        logic [32:0] sum;
        sum = {1'b0, pos} + {1'b0, Step32};
        return (sum > {1'b0, max}) ? max : sum[31:0];
    endfunction

    // Next position: unchanged on turn-only, otherwise one clamped step along the heading.
    always_comb begin
        o_x = i_x;
        o_y = i_y;
        if (i_move) begin
            unique case (i_dir)
                Up:    o_y = pos_dec(i_y);
                Right: o_x = pos_inc(i_x, XMax);
                Down:  o_y = pos_inc(i_y, YMax);
                Left:  o_x = pos_dec(i_x);
            endcase
        end
    end

endmodule

// File: rtl/tank_register_writer.sv
// Owns every tank's position and heading; once per frame applies the pending command
// of each tank and writes x, y and direction into that tank's controller.
module tank_register_writer
    import tank_pkg::*;
#(
    parameter int unsigned NUM_TANKS = 2,
    parameter int unsigned HALF_SIZE = 16,
    parameter int unsigned STEP      = 4,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    localparam int unsigned TW       = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_tick_i,
    input  logic          cmd_valid_i,
    input  logic [TW-1:0] cmd_tank_i,
    input  logic [1:0]    cmd_dir_i,
    input  logic          cmd_move_i,
    output logic          MW_o,
    output logic [1:0]    address_o,
    output logic [31:0]   data_o,
    output logic [TW-1:0] tank_sel_o,
    output logic          busy_o,
    output logic          overrun_o
);

    // Authoritative per-tank state.
    logic [31:0] r_x   [NUM_TANKS];
    logic [31:0] r_y   [NUM_TANKS];
    dir_t        r_dir [NUM_TANKS];

    // Latest command per tank, waiting for the next frame.
    logic        r_pend_valid [NUM_TANKS];
    dir_t        r_pend_dir   [NUM_TANKS];
    logic        r_pend_move  [NUM_TANKS];

    state_t        r_state;
    logic [TW-1:0] r_idx;
    logic          r_mw;
    logic [1:0]    r_addr;
    logic [31:0]   r_data;
    logic [TW-1:0] r_sel;
    logic          r_busy;
    logic          r_overrun;

    logic [31:0] w_next_x;
    logic [31:0] w_next_y;
    logic        w_step;
    logic        w_last;

    assign w_step = r_pend_valid[r_idx] & r_pend_move[r_idx];
    assign w_last = (r_idx == TW'(NUM_TANKS - 1));

    tank_pos_step_clamp #(
        .HALF_SIZE (HALF_SIZE),
        .STEP      (STEP),
        .H_RES     (H_RES),
        .V_RES     (V_RES)
    ) u_step_clamp (
        .i_x    (r_x[r_idx]),
        .i_y    (r_y[r_idx]),
        .i_dir  (r_pend_dir[r_idx]),
        .i_move (w_step),
        .o_x    (w_next_x),
        .o_y    (w_next_y)
    );

    // Command capture; a new command beats the clear from the same-cycle UPDATE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NUM_TANKS; n++) begin
                r_pend_valid[n] <= 1'b0;
                r_pend_dir[n]   <= Up;
                r_pend_move[n]  <= 1'b0;
            end
        end else begin
            for (int n = 0; n < NUM_TANKS; n++) begin
                if (cmd_valid_i && (cmd_tank_i == TW'(n))) begin
                    r_pend_valid[n] <= 1'b1;
                    r_pend_dir[n]   <= dir_t'(cmd_dir_i);
                    r_pend_move[n]  <= cmd_move_i;
                end else if ((r_state == StUpdate) && (r_idx == TW'(n))) begin
                    r_pend_valid[n] <= 1'b0;
                end
            end
        end
    end

    // Frame sequencer: per tank UPDATE then three register writes, outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_idx     <= '0;
            r_mw      <= 1'b0;
            r_addr    <= ADDR_X;
            r_data    <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
            for (int n = 0; n < NUM_TANKS; n++) begin
                r_x[n]   <= init_x(n);
                r_y[n]   <= init_y(n);
                r_dir[n] <= Up;
            end
        end else begin
            r_overrun <= frame_tick_i && (r_state != StIdle);
            unique case (r_state)
                StIdle: begin
                    if (frame_tick_i) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StUpdate;
                    end
                end
                StUpdate: begin
                    if (r_pend_valid[r_idx]) begin
                        r_dir[r_idx] <= r_pend_dir[r_idx];
                        r_x[r_idx]   <= w_next_x;
                        r_y[r_idx]   <= w_next_y;
                    end
                    // w_next_x equals the stored x when nothing moves.
                    r_mw    <= 1'b1;
                    r_sel   <= r_idx;
                    r_addr  <= ADDR_X;
                    r_data  <= w_next_x;
                    r_state <= StWrX;
                end
                StWrX: begin
                    r_addr  <= ADDR_Y;
                    r_data  <= r_y[r_idx];
                    r_state <= StWrY;
                end
                StWrY: begin
                    r_addr  <= ADDR_DIR;
                    r_data  <= 32'(r_dir[r_idx]);
                    r_state <= StWrDir;
                end
                StWrDir: begin
                    r_mw <= 1'b0;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_idx   <= r_idx + TW'(1);
                        r_state <= StUpdate;
                    end
                end
                default: begin
                    r_mw    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign MW_o       = r_mw;
    assign address_o  = r_addr;
    assign data_o     = r_data;
    assign tank_sel_o = r_sel;
    assign busy_o     = r_busy;
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_tank_register_writer.sv
// Scoreboard bench for tank_register_writer: stimulus pushes expected register writes
// from a behavioural model, a monitor pops and compares every MW_o cycle.
module tb_tank_register_writer;

    localparam int NT = 2;

    logic        clk;
    logic        rst;
    logic        frame_tick_i;
    logic        cmd_valid_i;
    logic [0:0]  cmd_tank_i;
    logic [1:0]  cmd_dir_i;
    logic        cmd_move_i;
    logic        MW_o;
    logic [1:0]  address_o;
    logic [31:0] data_o;
    logic [0:0]  tank_sel_o;
    logic        busy_o;
    logic        overrun_o;

    tank_register_writer #(
        .NUM_TANKS (NT),
        .HALF_SIZE (16),
        .STEP      (4),
        .H_RES     (640),
        .V_RES     (480)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_tank_i   (cmd_tank_i),
        .cmd_dir_i    (cmd_dir_i),
        .cmd_move_i   (cmd_move_i),
        .MW_o         (MW_o),
        .address_o    (address_o),
        .data_o       (data_o),
        .tank_sel_o   (tank_sel_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int addr;
        int data;
    } wr_t;

    wr_t q[$];
    int  checks = 0;
    int  errors = 0;

    // Behavioural model: screen coordinates, sprite centre kept in [16, W-16].
    int mx[NT], my[NT], mdir[NT], pd[NT];
    bit pv[NT], pm[NT];

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NT; n++) begin
            mx[n] = 60 + 30 * n;
            my[n] = 40 + 30 * n;
            mdir[n] = 0;
            pv[n] = 0;
            pd[n] = 0;
            pm[n] = 0;
        end
    endfunction

    function automatic void model_cmd(input int t, input int d, input bit m);
        pv[t] = 1;
        pd[t] = d;
        pm[t] = m;
    endfunction

    function automatic void model_frame();
        int dx, dy;
        for (int n = 0; n < NT; n++) begin
            if (pv[n]) begin
                mdir[n] = pd[n];
                if (pm[n]) begin
                    dx = (pd[n] == 1) ? 1 : (pd[n] == 3) ? -1 : 0;
                    dy = (pd[n] == 2) ? 1 : (pd[n] == 0) ? -1 : 0;
                    mx[n] = clampi(mx[n] + 4 * dx, 16, 640 - 16);
                    my[n] = clampi(my[n] + 4 * dy, 16, 480 - 16);
                end
                pv[n] = 0;
            end
            q.push_back('{sel: n, addr: 0, data: mx[n]});
            q.push_back('{sel: n, addr: 1, data: my[n]});
            q.push_back('{sel: n, addr: 2, data: mdir[n]});
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && MW_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual sel=%0d addr=%0d data=%0d required=none",
                         tank_sel_o, address_o, data_o);
            end else begin
                wr_t e;
                e = q.pop_front();
                if (tank_sel_o !== 1'(e.sel) || address_o !== 2'(e.addr) ||
                    data_o !== 32'(e.data)) begin
                    errors++;
                    $display("FAIL write actual sel=%0d addr=%0d data=%0d required sel=%0d addr=%0d data=%0d",
                             tank_sel_o, address_o, data_o, e.sel, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int t, input int d, input bit m);
        model_cmd(t, d, m);
        cmd_valid_i = 1'b1;
        cmd_tank_i  = 1'(t);
        cmd_dir_i   = 2'(d);
        cmd_move_i  = m;
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Leaves the caller in the cycle right after the tick was sampled.
    task automatic tick();
        model_frame();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("busy_cleared", busy_o, 0);
        step();
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        model_reset();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        frame_tick_i = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_tank_i   = '0;
        cmd_dir_i    = '0;
        cmd_move_i   = 1'b0;
        model_reset();
        #12;
        chk("rst_MW", MW_o, 0);
        chk("rst_address", address_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_tank_sel", tank_sel_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_overrun", overrun_o, 0);
        rst = 1'b0;
        step();

        // Initial positions and write timing: writes at T+2..4 and T+6..8, idle at T+9.
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("timing_MW_T+%0d", k), MW_o, ((k % 4) != 1) && (k <= 8));
            chk($sformatf("timing_busy_T+%0d", k), busy_o, (k <= 8));
            step();
        end
        wait_idle();

        // Turn right and step.
        send_cmd(0, 1, 1);
        tick();
        wait_idle();

        // Turn only.
        send_cmd(1, 2, 0);
        tick();
        wait_idle();

        // Walk tank 0 into the left edge.
        for (int i = 0; i < 14; i++) begin
            send_cmd(0, 3, 1);
            tick();
            wait_idle();
        end

        // Second tick while busy: one overrun pulse, no restart.
        tick();
        step();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        chk("overrun_pulse", overrun_o, 1);
        step();
        chk("overrun_one_cycle", overrun_o, 0);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            chk("no_restart_busy", busy_o, 0);
            step();
        end

        // Command landing on tank 0's UPDATE cycle stays pending; tank 1 command is used.
        send_cmd(0, 2, 1);
        model_cmd(1, 3, 1);
        model_frame();
        model_cmd(0, 1, 1);
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        cmd_valid_i = 1'b1;
        cmd_tank_i  = 1'b0;
        cmd_dir_i   = 2'd1;
        cmd_move_i  = 1'b1;
        step();
        cmd_tank_i  = 1'b1;
        cmd_dir_i   = 2'd3;
        step();
        cmd_valid_i = 1'b0;
        wait_idle();
        tick();
        wait_idle();

        // Reset during tank 0 WR_Y drops MW_o at once; next frame restarts from scratch.
        send_cmd(1, 0, 1);
        tick();
        step();
        step();
        chk("pre_reset_MW", MW_o, 1);
        chk("pre_reset_addr", address_o, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_MW_drop", MW_o, 0);
        chk("reset_busy_drop", busy_o, 0);
        do_reset();
        tick();
        wait_idle();

        // Randomized frames with random commands issued while idle.
        for (int f = 0; f < 30; f++) begin
            int ncmd;
            ncmd = $urandom_range(0, 3);
            for (int c = 0; c < ncmd; c++) begin
                send_cmd($urandom_range(0, NT - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
            tick();
            wait_idle();
        end

        step();
        chk("final_queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
